// File: rtl/xmt_buf.sv
// Transmit FIFO between the bus and the serial transmitter.
// Hands bytes to the transmitter one at a time using its load/empty handshake.
//
// state | meaning
// IDLE  | waiting for a stored byte and an empty transmitter
// LOAD  | xmt_load is high for this single cycle
// BUSY  | waiting for the transmitter to start (seen_busy=0), then to finish
module xmt_buf #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  input  logic                clr_ovf,
  output logic                idle,
  output logic                xmt_load,
  output logic [7:0]          xmt_data,
  input  logic                xmt_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;

  state_t                state;
  logic                  seen_busy;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  wr_ok;
  logic                  wr_drop;
  logic                  pop;

  // Full is judged on the pre-edge level, so a write while full is dropped
  // even when a pop frees a slot on the same edge.
  assign full    = (level == LVL_FULL);
  assign wr_ok   = wr && !full;
  assign wr_drop = wr && full;
  assign pop     = (state == IDLE) && (level != '0) && xmt_empty;
  assign idle    = (state == IDLE) && (level == '0) && xmt_empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      case ({wr_ok, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (wr_drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rptr      <= '0;
      xmt_load  <= 1'b0;
      xmt_data  <= 8'h00;
      seen_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            xmt_data <= mem[rptr];
            rptr     <= rptr + PTR_ONE;
            xmt_load <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          xmt_load  <= 1'b0;
          seen_busy <= 1'b0;
          state     <= BUSY;
        end
        BUSY: begin
          // A lingering empty before the transmitter drops it is not completion.
          if (!seen_busy) begin
            if (!xmt_empty) begin
              seen_busy <= 1'b1;
            end
          end else if (xmt_empty) begin
            seen_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          xmt_load <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xmt_buf.sv
// Bench for xmt_buf: queue-based reference model checked every cycle, a serial
// transmitter/receiver pair on the output, and directed scenarios with literal checks.
`timescale 1ns/1ps
module tb_xmt_buf;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int BIT_LEN    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr = 1'b0;
  logic clr_ovf = 1'b0;
  logic hold_busy = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, overflow, idle, xmt_load, xmt_empty;
  logic [DEPTH_LOG2:0] level;
  logic [7:0] xmt_data;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int loads = 0;
  int base;

  xmt_buf #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_data(wr_data), .full(full), .level(level),
    .overflow(overflow), .clr_ovf(clr_ovf), .idle(idle), .xmt_load(xmt_load),
    .xmt_data(xmt_data), .xmt_empty(xmt_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Transmitter: start bit, 8 data bits LSB first, stop bit, BIT_LEN cycles each.
  logic tx_busy = 1'b0;
  logic txd = 1'b1;
  logic [9:0] tx_sh = '0;
  int tx_bit = 0;
  int tx_ph = 0;
  assign xmt_empty = !tx_busy && !hold_busy;

  always @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      txd     <= 1'b1;
    end else if (!tx_busy) begin
      txd <= 1'b1;
      if (xmt_load) begin
        tx_sh   <= {1'b1, xmt_data, 1'b0};
        tx_busy <= 1'b1;
        tx_bit  <= 0;
        tx_ph   <= 0;
        txd     <= 1'b0;
      end
    end else if (tx_ph == BIT_LEN-1) begin
      tx_ph <= 0;
      if (tx_bit == 9) begin
        tx_busy <= 1'b0;
        txd     <= 1'b1;
      end else begin
        tx_bit <= tx_bit + 1;
        txd    <= tx_sh[tx_bit+1];
      end
    end else begin
      tx_ph <= tx_ph + 1;
    end
  end

  // Receiver decoding the serial line independently of the transmitter internals.
  int rx_ph = 0;
  int rx_n = 0;
  bit rx_act = 1'b0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (!txd) begin
        rx_act = 1'b1;
        rx_ph = 0;
        rx_n = 0;
      end
    end else begin
      rx_ph++;
      if (rx_ph == BIT_LEN) begin
        rx_ph = 0;
        rx_n++;
        if (rx_n <= 8) rx_sh = {txd, rx_sh[7:1]};
        else begin
          rx_q.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) if (xmt_load) loads++;

  // Reference model: byte queue plus a handoff that is free, just loaded,
  // waiting for the transmitter to start, or waiting for it to finish.
  logic [7:0] mq[$];
  bit m_ready = 1'b1;
  bit m_load = 1'b0;
  bit m_seen = 1'b0;
  bit m_ovf = 1'b0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk) begin : model
    bit pop, was_load, full_pre;
    if (rst) begin
      mq.delete();
      m_ready = 1'b1;
      m_load = 1'b0;
      m_seen = 1'b0;
      m_ovf = 1'b0;
      m_data = 8'h00;
    end else begin
      was_load = m_load;
      full_pre = (mq.size() == DEPTH);
      pop = m_ready && (mq.size() != 0) && xmt_empty;
      if (pop) m_data = mq.pop_front();
      if (wr && !full_pre) mq.push_back(wr_data);
      if (wr && full_pre) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_load = pop;
      if (pop) begin
        m_ready = 1'b0;
        m_seen = 1'b0;
      end else if (!m_ready && !was_load) begin
        if (!m_seen) begin
          if (!xmt_empty) m_seen = 1'b1;
        end else if (xmt_empty) begin
          m_ready = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("model level", level, mq.size());
      chk("model full", full, mq.size() == DEPTH);
      chk("model overflow", overflow, m_ovf);
      chk("model xmt_load", xmt_load, m_load);
      chk("model xmt_data", xmt_data, m_data);
      chk("model idle", idle, (mq.size() == 0) && m_ready && xmt_empty);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    wr = 1'b1;
    wr_data = b;
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (!idle && n < max) begin
      tick();
      n++;
    end
    chk(name, idle, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp5[6];
    exp5[0] = 8'h20; exp5[1] = 8'h21; exp5[2] = 8'h22;
    exp5[3] = 8'h23; exp5[4] = 8'h24; exp5[5] = 8'h55;

    repeat (3) tick();
    chk("reset level", level, 0);
    chk("reset full", full, 0);
    chk("reset overflow", overflow, 0);
    chk("reset xmt_load", xmt_load, 0);
    chk("reset xmt_data", xmt_data, 8'h00);
    chk("reset idle", idle, 1);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // 1: single byte latency
    rx_q.delete();
    base = loads;
    push(8'h41);
    chk("t1 level after write", level, 1);
    chk("t1 load not yet", xmt_load, 0);
    tick();
    chk("t1 load high", xmt_load, 1);
    chk("t1 data", xmt_data, 8'h41);
    chk("t1 level after pop", level, 0);
    tick();
    chk("t1 load one cycle", xmt_load, 0);
    chk("t1 transmitter started", xmt_empty, 0);
    wait_idle(60, "t1 idle reached");
    chk("t1 load count", loads - base, 1);
    chk("t1 rx count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t1 rx byte", rx_q[0], 8'h41);

    // 2: fill to full with the transmitter held busy
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2 full", full, 1);
    chk("t2 level", level, 16);
    chk("t2 overflow", overflow, 0);

    // 3: overflow, clear, and set-wins-over-clear
    push(8'hAA);
    chk("t3 overflow set", overflow, 1);
    chk("t3 level", level, 16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3 overflow cleared", overflow, 0);
    wr = 1'b1; wr_data = 8'hAB; clr_ovf = 1'b1;
    tick();
    wr = 1'b0; clr_ovf = 1'b0;
    chk("t3 set wins", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3 overflow cleared again", overflow, 0);

    // 4: drain through the serial line
    rx_q.delete();
    base = loads;
    hold_busy = 1'b0;
    wait_idle(16 * 30, "t4 idle reached");
    chk("t4 level", level, 0);
    chk("t4 load count", loads - base, 16);
    chk("t4 rx count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) chk("t4 rx byte", rx_q[i], i);

    // 5: write and pop on the same edge at level 5
    rx_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    chk("t5 level before", level, 5);
    hold_busy = 1'b0;
    wr = 1'b1;
    wr_data = 8'h55;
    tick();
    wr = 1'b0;
    chk("t5 level held", level, 5);
    chk("t5 load", xmt_load, 1);
    chk("t5 data", xmt_data, 8'h20);
    wait_idle(6 * 30, "t5 idle reached");
    chk("t5 rx count", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) chk("t5 rx order", rx_q[i], exp5[i]);

    // 6: reset while transmitting with bytes still queued
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
    hold_busy = 1'b0;
    repeat (4) tick();
    chk("t6 level before reset", level, 3);
    chk("t6 transmitter busy", xmt_empty, 0);
    rst = 1'b1;
    tick();
    chk("t6 level", level, 0);
    chk("t6 full", full, 0);
    chk("t6 xmt_load", xmt_load, 0);
    chk("t6 idle", idle, 1);
    rst = 1'b0;
    base = loads;
    repeat (40) tick();
    chk("t6 no loads after reset", loads - base, 0);
    chk("t6 level stays", level, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
